// File: rtl/mem_access_ctrl.sv
// Memory-stage request initiator: decodes icode, issues one req/ack access, returns valM.
// Define ALIGN_CHECK_EN to reject memory ops whose address is not 8-byte aligned.
module mem_access_ctrl #(
  parameter int MEM_DEPTH = 8192,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] valM,
  output logic        busy,
  output logic        done,
  output logic        dmem_error
);

  localparam logic [63:0]      MAX_ADDR  = 64'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             we_reg, we_next;
  logic [63:0]      addr_reg, addr_next;
  logic [63:0]      wdata_reg, wdata_next;
  logic [63:0]      valm_reg, valm_next;
  logic             err_reg, err_next;
  logic             settle_reg, settle_next;

  logic             dec_mem;
  logic             dec_we;
  logic             dec_bad;
  logic [63:0]      dec_addr;
  logic [63:0]      dec_data;

  // Instruction decode: which operand forms the address and which the store data.
  always_comb begin
    dec_mem  = 1'b0;
    dec_we   = 1'b0;
    dec_addr = valE;
    dec_data = valA;
    case (icode)
      4'd4:  begin dec_mem = 1'b1; dec_we = 1'b1; end
      4'd5:  begin dec_mem = 1'b1; end
      4'd8:  begin dec_mem = 1'b1; dec_we = 1'b1; dec_data = valP; end
      4'd9:  begin dec_mem = 1'b1; dec_addr = valA; end
      4'd10: begin dec_mem = 1'b1; dec_we = 1'b1; end
      4'd11: begin dec_mem = 1'b1; dec_addr = valA; end
      default: begin dec_mem = 1'b0; end
    endcase
  end

  always_comb begin
    dec_bad = dec_mem && (dec_addr > MAX_ADDR);
`ifdef ALIGN_CHECK_EN
    if (dec_mem && (dec_addr[2:0] != 3'b000)) begin
      dec_bad = 1'b1;
    end
`else
    dec_bad = dec_bad;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      valm_reg   <= '0;
      err_reg    <= 1'b0;
      settle_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      valm_reg   <= valm_next;
      err_reg    <= err_next;
      settle_reg <= settle_next;
    end
  end

  // settle_reg gives non-memory and rejected starts the same two-cycle
  // start-to-done latency as an access acked on its first request cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    valm_next   = valm_reg;
    err_next    = err_reg;
    settle_next = settle_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next = '0;
          err_next = 1'b0;
          if (dec_mem && !dec_bad) begin
            we_next    = dec_we;
            addr_next  = dec_addr;
            wdata_next = dec_data;
            state_next = REQ;
          end else begin
            err_next    = dec_bad;
            settle_next = 1'b1;
            state_next  = DONE;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!we_reg) begin
            valm_next = mem_rdata;
          end
          settle_next = 1'b0;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == CNT_LIMIT) begin
            err_next    = 1'b1;
            settle_next = 1'b0;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        if (settle_reg) begin
          settle_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req    = (state_reg == REQ);
  assign mem_we     = we_reg && (state_reg == REQ);
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign valM       = valm_reg;
  assign dmem_error = err_reg;
  assign busy       = (state_reg == REQ) || ((state_reg == DONE) && settle_reg);
  assign done       = (state_reg == DONE) && !settle_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scoreboard of expected completions.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] valM;
  logic        busy;
  logic        done;
  logic        dmem_error;

  mem_access_ctrl #(.MEM_DEPTH(8192), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valM(valM), .busy(busy), .done(done), .dmem_error(dmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   req_cnt = 0;
  logic [63:0] exp_valm = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_req === 1'b1) req_cnt++;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, input logic err, input int lat, input int reqs);
    exp_t x;
    icode = ic; valA = a; valE = e; valP = p;
    start = 1'b1;
    start_cyc = cyc;
    req_cnt = 0;
    x.valm = exp_valm; x.err = err; x.lat = lat; x.reqs = reqs;
    sb.push_back(x);
    $display("start icode=%0d valA=%h valE=%h valP=%h", ic, a, e, p);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int   n;
    exp_t x;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      x = sb.pop_front();
      chk("latency", 64'(cyc - start_cyc), 64'(x.lat));
      chk("valM", valM, x.valm);
      chk("dmem_error", 64'(dmem_error), 64'(x.err));
      chk("req_cycles", 64'(req_cnt), 64'(x.reqs));
      $display("done latency=%0d valM=%h err=%0b req_cycles=%0d", cyc - start_cyc, valM, dmem_error, req_cnt);
    end
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(dmem_error), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    step();

    // rmmovq write, acked after three waiting cycles
    issue(4'd4, 64'hDEAD, 64'h10, 64'h0, 1'b0, 5, 4);
    chk("t1_req", 64'(mem_req), 64'd1);
    chk("t1_we", 64'(mem_we), 64'd1);
    chk("t1_addr", mem_addr, 64'h10);
    chk("t1_wdata", mem_wdata, 64'hDEAD);
    chk("t1_busy", 64'(busy), 64'd1);
    step(); step(); step();
    chk("t1_addr_stable", mem_addr, 64'h10);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wait_done(10);

    // popq read, acked on first request cycle
    exp_valm = 64'h1234;
    issue(4'd11, 64'h20, 64'h0, 64'h0, 1'b0, 2, 1);
    chk("t2_we", 64'(mem_we), 64'd0);
    chk("t2_addr", mem_addr, 64'h20);
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    step();
    mem_ack = 1'b0;
    wait_done(10);

    // out-of-range call, then non-memory icode
    issue(4'd8, 64'h0, 64'h2000, 64'h55, 1'b1, 2, 0);
    chk("t3_busy", 64'(busy), 64'd1);
    wait_done(10);
    issue(4'd1, 64'h0, 64'h0, 64'h0, 1'b0, 2, 0);
    wait_done(10);

    // highest valid address
`ifdef ALIGN_CHECK_EN
    issue(4'd4, 64'h1, 64'h1FFF, 64'h0, 1'b1, 2, 0);
    wait_done(10);
`else
    issue(4'd4, 64'h1, 64'h1FFF, 64'h0, 1'b0, 2, 1);
    chk("t_edge_addr", mem_addr, 64'h1FFF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wait_done(10);
`endif

    // mrmovq never acked: times out after 16 request cycles
    issue(4'd5, 64'h0, 64'h8, 64'h0, 1'b1, 17, 16);
    wait_done(40);

    // ret acked on the 16th request cycle: ack beats timeout
    exp_valm = 64'hAB;
    issue(4'd9, 64'h18, 64'h0, 64'h0, 1'b0, 17, 16);
    for (int i = 0; i < 15; i++) step();
    mem_ack = 1'b1; mem_rdata = 64'hAB;
    step();
    mem_ack = 1'b0;
    wait_done(10);

    // ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 64'hFFFF;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_valM", valM, exp_valm);
    chk("idle_ack_busy", 64'(busy), 64'd0);
    chk("idle_ack_req", 64'(mem_req), 64'd0);

    // pushq to an unaligned address
`ifdef ALIGN_CHECK_EN
    issue(4'd10, 64'h77, 64'h9, 64'h0, 1'b1, 2, 0);
    wait_done(10);
`else
    issue(4'd10, 64'h77, 64'h9, 64'h0, 1'b0, 2, 1);
    chk("t5_addr", mem_addr, 64'h9);
    chk("t5_wdata", mem_wdata, 64'h77);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wait_done(10);
`endif

    // second start while busy is ignored; reset mid-request clears everything
    issue(4'd5, 64'h0, 64'h8, 64'h0, 1'b0, 0, 0);
    icode = 4'd4; valE = 64'h100; valA = 64'h5; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_we_kept", 64'(mem_we), 64'd0);
    chk("t6_addr_kept", mem_addr, 64'h8);
    chk("t6_req", 64'(mem_req), 64'd1);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 64'(mem_req), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_valM", valM, 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_addr", mem_addr, 64'd0);
    $display("reset mid-request req=%0b busy=%0b valM=%h", mem_req, busy, valM);
    sb.delete();
    exp_valm = '0;
    step();
    rst = 1'b0;
    step();
    issue(4'd1, 64'h0, 64'h0, 64'h0, 1'b0, 2, 0);
    wait_done(10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
